// File: rtl/memory_stage_ext.sv
// MIPS memory stage: E->M pipeline register, DEPTH-word byte-laned data memory,
// sub-word loads/stores and a WAIT_STATES stall FSM. Optional MSX_ALIGN_CHECK_EN adds misalignment trapping.
module memory_stage_ext #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic             MSX_CLK,
    input  logic             MSX_RST,
    input  logic [WIDTH-1:0] MSX_AluOutE,
    input  logic [WIDTH-1:0] MSX_WriteDataE,
    input  logic [4:0]       MSX_WriteRegE,
    input  logic             MSX_RegWriteE,
    input  logic             MSX_MemWriteE,
    input  logic             MSX_MemToRegE,
    input  logic [1:0]       MSX_MemSizeE,
    input  logic             MSX_MemSignedE,
    input  logic             MSX_FlushE,
    output logic [WIDTH-1:0] MSX_AluOutM,
    output logic [WIDTH-1:0] MSX_ReadDataM,
    output logic [4:0]       MSX_WriteRegM,
    output logic             MSX_RegWriteM,
    output logic             MSX_MemToRegM,
    output logic             MSX_StallM,
    output logic             MSX_MisalignM
);
    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [WIDTH-1:0] r_alu, r_wd;
    logic [4:0]       r_wreg;
    logic             r_regwrite, r_memwrite, r_memtoreg, r_signed;
    logic [1:0]       r_size;
    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_memop, w_stall, w_misalign, w_commit;
    logic [AW-1:0]    w_idx;
    logic [WIDTH-1:0] w_rd_word, w_lanes, w_wr_word, w_load;
    logic [3:0]       w_be;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic             w_unused_ok;

    assign w_memop     = r_memwrite | r_memtoreg;
    assign w_idx       = r_alu[AW+1:2];
    assign w_rd_word   = r_mem[w_idx];
    assign w_unused_ok = &{1'b0, r_alu[WIDTH-1:AW+2]};

    // Stall is held until the final M cycle of a memory op; only then may it commit.
    always_comb begin
        w_stall = 1'b0;
        if (WS != 4'd0) begin
            if (r_state == S_IDLE) w_stall = w_memop;
            else                   w_stall = (r_cnt < WS);
        end
    end

`ifdef MSX_ALIGN_CHECK_EN
    assign w_misalign = w_memop &&
                        (((r_size == 2'b01) && r_alu[0]) ||
                         (r_size[1] && (r_alu[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_commit = r_memwrite && !w_stall && !w_misalign;

    always_comb begin
        w_be    = 4'b1111;
        w_lanes = r_wd;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_alu[1:0];
                w_lanes = {4{r_wd[7:0]}};
            end
            2'b01: begin
                w_be    = r_alu[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{r_wd[15:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++)
            w_wr_word[8*i +: 8] = w_be[i] ? w_lanes[8*i +: 8] : w_rd_word[8*i +: 8];
    end

    // Right-justify the selected lanes, then extend.
    always_comb begin
        w_byte = w_rd_word[8*r_alu[1:0] +: 8];
        w_half = r_alu[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = w_rd_word;
        endcase
        if (!r_memtoreg)     w_load = w_rd_word;
        else if (w_misalign) w_load = '0;
    end

    always_ff @(posedge MSX_CLK or posedge MSX_RST) begin
        if (MSX_RST) begin
            r_alu      <= '0;
            r_wd       <= '0;
            r_wreg     <= '0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
        end else if (!w_stall) begin
            if (MSX_FlushE) begin
                r_alu      <= '0;
                r_wd       <= '0;
                r_wreg     <= '0;
                r_regwrite <= 1'b0;
                r_memwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_size     <= 2'b00;
                r_signed   <= 1'b0;
            end else begin
                r_alu      <= MSX_AluOutE;
                r_wd       <= MSX_WriteDataE;
                r_wreg     <= MSX_WriteRegE;
                r_regwrite <= MSX_RegWriteE;
                r_memwrite <= MSX_MemWriteE;
                r_memtoreg <= MSX_MemToRegE;
                r_size     <= MSX_MemSizeE;
                r_signed   <= MSX_MemSignedE;
            end
        end
    end

    always_ff @(posedge MSX_CLK or posedge MSX_RST) begin
        if (MSX_RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_memop && (WS != 4'd0)) begin
                    r_state <= S_WAIT;
                    r_cnt   <= 4'd1;
                end
                S_WAIT: if (r_cnt < WS) begin
                    r_cnt <= r_cnt + 4'd1;
                end else begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Reset clears the whole array, which also drops any store still in flight.
    always_ff @(posedge MSX_CLK or posedge MSX_RST) begin
        if (MSX_RST) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    assign MSX_AluOutM   = r_alu;
    assign MSX_ReadDataM = w_load;
    assign MSX_WriteRegM = r_wreg;
    assign MSX_RegWriteM = r_regwrite;
    assign MSX_MemToRegM = r_memtoreg;
    assign MSX_StallM    = w_stall;
    assign MSX_MisalignM = w_misalign;
endmodule

// File: tb/tb_memory_stage_ext.sv
// Directed bench for memory_stage_ext: one instance with WAIT_STATES=0, one with WAIT_STATES=2.
module tb_memory_stage_ext;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] e0_alu, e0_wd, e2_alu, e2_wd;
    logic [4:0]  e0_wreg, e2_wreg;
    logic        e0_rw, e0_mw, e0_mtr, e0_sg, e0_fl;
    logic        e2_rw, e2_mw, e2_mtr, e2_sg, e2_fl;
    logic [1:0]  e0_sz, e2_sz;

    logic [31:0] m0_alu, m0_rd, m2_alu, m2_rd;
    logic [4:0]  m0_wreg, m2_wreg;
    logic        m0_rw, m0_mtr, m0_stall, m0_mis;
    logic        m2_rw, m2_mtr, m2_stall, m2_mis;

    memory_stage_ext #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .MSX_CLK(clk), .MSX_RST(rst),
        .MSX_AluOutE(e0_alu), .MSX_WriteDataE(e0_wd), .MSX_WriteRegE(e0_wreg),
        .MSX_RegWriteE(e0_rw), .MSX_MemWriteE(e0_mw), .MSX_MemToRegE(e0_mtr),
        .MSX_MemSizeE(e0_sz), .MSX_MemSignedE(e0_sg), .MSX_FlushE(e0_fl),
        .MSX_AluOutM(m0_alu), .MSX_ReadDataM(m0_rd), .MSX_WriteRegM(m0_wreg),
        .MSX_RegWriteM(m0_rw), .MSX_MemToRegM(m0_mtr),
        .MSX_StallM(m0_stall), .MSX_MisalignM(m0_mis)
    );

    memory_stage_ext #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) dut2 (
        .MSX_CLK(clk), .MSX_RST(rst),
        .MSX_AluOutE(e2_alu), .MSX_WriteDataE(e2_wd), .MSX_WriteRegE(e2_wreg),
        .MSX_RegWriteE(e2_rw), .MSX_MemWriteE(e2_mw), .MSX_MemToRegE(e2_mtr),
        .MSX_MemSizeE(e2_sz), .MSX_MemSignedE(e2_sg), .MSX_FlushE(e2_fl),
        .MSX_AluOutM(m2_alu), .MSX_ReadDataM(m2_rd), .MSX_WriteRegM(m2_wreg),
        .MSX_RegWriteM(m2_rw), .MSX_MemToRegM(m2_mtr),
        .MSX_StallM(m2_stall), .MSX_MisalignM(m2_mis)
    );

    task automatic set0(input logic mw, input logic mtr, input logic rw, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d, input logic fl);
        e0_mw = mw; e0_mtr = mtr; e0_rw = rw; e0_sz = sz; e0_sg = sg;
        e0_alu = a; e0_wd = d; e0_fl = fl; e0_wreg = 5'd7;
    endtask

    task automatic set2(input logic mw, input logic mtr, input logic rw, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d, input logic fl);
        e2_mw = mw; e2_mtr = mtr; e2_rw = rw; e2_sz = sz; e2_sg = sg;
        e2_alu = a; e2_wd = d; e2_fl = fl; e2_wreg = 5'd9;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set0(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
        set2(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0);
        rst = 1'b1;
        step();
        step();
        n_vec++;
        if ({m0_alu, m0_wreg, m0_rw, m0_mtr, m0_stall, m0_mis} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_m0 got alu=%h wreg=%0d rw=%b mtr=%b st=%b mis=%b want all 0",
                     m0_alu, m0_wreg, m0_rw, m0_mtr, m0_stall, m0_mis);
        end
        n_vec++;
        if ({m2_alu, m2_wreg, m2_rw, m2_mtr, m2_stall, m2_mis} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_m2 got alu=%h st=%b want all 0", m2_alu, m2_stall);
        end
        set0(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        set2(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_subword_loads();
        logic [31:0] exp_tab [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_0001, 32'hFFFF_80FF, 32'h0000_80FF};
        logic [1:0]  sz_tab  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg_tab  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad_tab  [5] = '{32'h12, 32'h12, 32'h10, 32'h12, 32'h12};
        set0(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            set0(1'b0, 1'b1, 1'b1, sz_tab[i], sg_tab[i], ad_tab[i], 32'h0, 1'b0);
            step();
            n_vec++;
            if (m0_rd !== exp_tab[i]) begin
                n_err++;
                $display("FAIL load_ext[%0d] got %h want %h", i, m0_rd, exp_tab[i]);
            end
        end
        n_vec++;
        if ({m0_alu, m0_wreg, m0_rw, m0_mtr} !== {32'h12, 5'd7, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL m_fields got alu=%h wreg=%0d rw=%b mtr=%b want 12/7/1/1",
                     m0_alu, m0_wreg, m0_rw, m0_mtr);
        end
    endtask

    task automatic test_subword_stores();
        set0(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        step();
        set0(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h21, 32'hDEAD_BEAB, 1'b0);
        step();
        set0(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        step();
        n_vec++;
        if (m0_rd !== 32'h0000_AB00) begin
            n_err++;
            $display("FAIL store_byte got %h want 0000ab00", m0_rd);
        end
        set0(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'hCAFE_1234, 1'b0);
        step();
        set0(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        step();
        n_vec++;
        if (m0_rd !== 32'h1234_AB00) begin
            n_err++;
            $display("FAIL store_half got %h want 1234ab00", m0_rd);
        end
        n_vec++;
        if (m0_stall !== 1'b0) begin
            n_err++;
            $display("FAIL no_stall_ws0 got %b want 0", m0_stall);
        end
    endtask

    task automatic test_flush();
        set0(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h1111_1111, 1'b1);
        step();
        n_vec++;
        if ({m0_rw, m0_alu} !== 33'd0) begin
            n_err++;
            $display("FAIL flush_bubble got rw=%b alu=%h want 0/0", m0_rw, m0_alu);
        end
        set0(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0);
        step();
        step();
        n_vec++;
        if (m0_rd !== 32'h0) begin
            n_err++;
            $display("FAIL flush_no_store got %h want 00000000", m0_rd);
        end
    endtask

    task automatic test_align();
        set0(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h30, 32'hAAAA_5555, 1'b0);
        step();
        set0(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h31, 32'h0000_BEEF, 1'b0);
        step();
`ifdef MSX_ALIGN_CHECK_EN
        n_vec++;
        if (m0_mis !== 1'b1) begin
            n_err++;
            $display("FAIL misalign_flag got %b want 1", m0_mis);
        end
`else
        n_vec++;
        if (m0_mis !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_flag got %b want 0", m0_mis);
        end
`endif
        set0(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);
        step();
        n_vec++;
`ifdef MSX_ALIGN_CHECK_EN
        if (m0_rd !== 32'hAAAA_5555) begin
            n_err++;
            $display("FAIL misalign_store got %h want aaaa5555", m0_rd);
        end
`else
        if (m0_rd !== 32'hAAAA_BEEF) begin
            n_err++;
            $display("FAIL misalign_store got %h want aaaabeef", m0_rd);
        end
`endif
        set0(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_wait_states();
        logic [2:0] stall_seen;
        set2(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h5A5A_1234, 1'b0);
        step();
        set2(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        stall_seen = {m2_stall, 2'b00};
        step();
        stall_seen[1] = m2_stall;
        n_vec++;
        if (m2_alu !== 32'h40 || dut2.r_mem[16] !== 32'h0) begin
            n_err++;
            $display("FAIL ws_hold got alu=%h mem=%h want 40/0", m2_alu, dut2.r_mem[16]);
        end
        step();
        stall_seen[0] = m2_stall;
        n_vec++;
        if (stall_seen !== 3'b110) begin
            n_err++;
            $display("FAIL ws_store_stall got %b want 110", stall_seen);
        end
        n_vec++;
        if (m2_alu !== 32'h40 || m2_mtr !== 1'b0 || dut2.r_mem[16] !== 32'h0) begin
            n_err++;
            $display("FAIL ws_pre_commit got alu=%h mtr=%b mem=%h want 40/0/0",
                     m2_alu, m2_mtr, dut2.r_mem[16]);
        end
        step();
        stall_seen = {m2_stall, 2'b00};
        n_vec++;
        if (dut2.r_mem[16] !== 32'h5A5A_1234 || m2_mtr !== 1'b1) begin
            n_err++;
            $display("FAIL ws_commit got mem=%h mtr=%b want 5a5a1234/1", dut2.r_mem[16], m2_mtr);
        end
        step();
        stall_seen[1] = m2_stall;
        step();
        stall_seen[0] = m2_stall;
        n_vec++;
        if (stall_seen !== 3'b110) begin
            n_err++;
            $display("FAIL ws_load_stall got %b want 110", stall_seen);
        end
        n_vec++;
        if (m2_rd !== 32'h5A5A_1234) begin
            n_err++;
            $display("FAIL ws_load_data got %h want 5a5a1234", m2_rd);
        end
        set2(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
    endtask

    task automatic test_flush_during_stall();
        set2(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h48, 32'h0000_0077, 1'b0);
        step();
        set2(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h99, 32'h0, 1'b1);
        step();
        step();
        n_vec++;
        if (m2_alu !== 32'h48 || m2_rw !== 1'b1) begin
            n_err++;
            $display("FAIL flush_stall_hold got alu=%h rw=%b want 48/1", m2_alu, m2_rw);
        end
        step();
        n_vec++;
        if (m2_rw !== 1'b0 || m2_alu !== 32'h0) begin
            n_err++;
            $display("FAIL flush_stall_bubble got rw=%b alu=%h want 0/0", m2_rw, m2_alu);
        end
        set2(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h48, 32'h0, 1'b0);
        for (int i = 0; i < 10 && !(m2_mtr === 1'b1 && m2_stall === 1'b0); i++) step();
        n_vec++;
        if (m2_rd !== 32'h0000_0077 || m2_stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall_complete got rd=%h st=%b want 00000077/0", m2_rd, m2_stall);
        end
        set2(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_access();
        set2(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h44, 32'hDEAD_BEEF, 1'b0);
        step();
        step();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({m2_stall, m2_rw, m2_alu} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_mid got st=%b rw=%b alu=%h want 0/0/0", m2_stall, m2_rw, m2_alu);
        end
        set2(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        set2(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0);
        set0(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        step();
        n_vec++;
        if (m0_rd !== 32'h0) begin
            n_err++;
            $display("FAIL reset_clears_mem got %h want 00000000", m0_rd);
        end
        step();
        step();
        n_vec++;
        if (m2_rd !== 32'h0 || m2_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drops_store got rd=%h st=%b want 00000000/0", m2_rd, m2_stall);
        end
    endtask

    initial begin
        test_reset();
        test_subword_loads();
        test_subword_stores();
        test_flush();
        test_align();
        test_wait_states();
        test_flush_during_stall();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/memory_stage_ext.md
# memory_stage_ext

Parametrised MIPS pipeline memory stage: the execute-to-memory pipeline register, a DEPTH-word data memory, sub-word loads/stores with sign/zero extension, and a configurable multi-cycle access with a stall handshake to the hazard unit. It sits between the execute stage and the writeback register and replaces the single-cycle, word-only memory stage.

## Interface
- WIDTH, 32, datapath width; only 32 is supported because byte lanes are defined on a 32-bit word
- DEPTH, 256, data memory depth in words, power of two, minimum 4
- WAIT_STATES, 0, extra cycles per load or store, range 0..15
- MSX_CLK  in  1  clock, rising edge
- MSX_RST  in  1  reset, asynchronous, active-high
- MSX_AluOutE  in  WIDTH  ALU result or byte address from execute
- MSX_WriteDataE  in  WIDTH  store data
- MSX_WriteRegE  in  5  destination register
- MSX_RegWriteE, MSX_MemWriteE, MSX_MemToRegE  in  1 each  control bits
- MSX_MemSizeE  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- MSX_MemSignedE  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- MSX_FlushE  in  1  load a bubble into the M register
- MSX_AluOutM, MSX_ReadDataM  out  WIDTH  M-stage ALU result and load data (extended)
- MSX_WriteRegM  out  5;  MSX_RegWriteM, MSX_MemToRegM  out  1  forwarded to writeback
- MSX_StallM  out  1  M-stage busy; upstream must hold and the writeback register must not load
- MSX_MisalignM  out  1  misaligned access flag

## Operation
- M register: captures all E inputs on a clock edge when MSX_StallM=0. It holds when MSX_StallM=1. If MSX_FlushE=1 and the register is not stalled, it loads a bubble: RegWrite, MemWrite and MemToReg are 0, and the other fields are 0.
- Stall wins over flush, so a stalled instruction always completes.
- A memory op is MemWriteM or MemToRegM.
- Word index is AluOutM[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
- Byte lanes are little-endian: lane n is bits 8n+7:8n.
- Stores:
  - byte writes WriteDataM[7:0] to lane AluOutM[1:0]
  - half writes WriteDataM[15:0] to lanes {2·AluOutM[1]+1, 2·AluOutM[1]}
  - word writes all lanes
  - untouched lanes keep their value
- Loads: the read is combinational from the array. The selected lane or lanes are right-justified, then sign- or zero-extended per MemSignedM. ReadDataM is don't-care when MemToRegM=0 and is driven as the raw word.
- Access FSM, with counter cnt (4 bits):
  - IDLE (cnt=0): if a memory op is in M and WAIT_STATES>0, StallM=1 and the FSM goes to WAIT with cnt=1.
  - WAIT: StallM=1 while cnt<WAIT_STATES and cnt increments. At cnt=WAIT_STATES, StallM=0, and the next edge returns to IDLE with cnt=0.
  - The store commits, and ReadDataM is valid, only on the edge or cycle where StallM=0.
- WAIT_STATES=0: StallM is constantly 0 and behaviour is single-cycle.
- Reset: all M-register outputs are 0, StallM=0, MisalignM=0, cnt=0, FSM=IDLE, and every memory word is 0. Reset mid-access drops the pending store.

## Timing
- E→M latency is 1 edge; a store is written at the edge ending its final M cycle.
- Total M occupancy per memory op is 1+WAIT_STATES cycles. Non-memory instructions take 1 cycle.
- Back-to-back memory ops each pay the full WAIT_STATES, because the FSM returns to IDLE between them.
- StallM and MisalignM are combinational from registered state; neither depends on E inputs.

## Configuration
- MSX_ALIGN_CHECK_EN defined:
  - A half access with AluOutM[0]=1, or a word access (size 10 or 11) with AluOutM[1:0]≠0, sets MisalignM=1 for every M cycle of that instruction.
  - The store is suppressed and load data is forced to 0.
  - The stall timing is unchanged.
- Not defined: MisalignM is tied to 0. Half accesses ignore AluOutM[0], word accesses ignore AluOutM[1:0], and no access is suppressed.

## Test plan
- Reset asserted mid-stream → all outputs 0, StallM=0; a load of word 0 after reset returns 0x00000000.
- WAIT_STATES=0:
  - sw 0x80FF7F01 at 0x10 → lb 0x12 = 0xFFFFFFFF, lbu 0x12 = 0x000000FF, lb 0x10 = 0x00000001, lh 0x12 = 0xFFFF80FF, lhu 0x12 = 0x000080FF.
  - sw 0 at 0x20, then sb 0x…AB at 0x21 → lw 0x20 = 0x0000AB00. sh 0x1234 at 0x22 → lw 0x20 = 0x1234AB00.
- WAIT_STATES=2: sw at 0x40 → StallM=1 for exactly 2 cycles with the following instruction held in E. The memory word is unchanged until the third edge. An lw issued next also sees StallM for 2 cycles and then reads the new value.
- FlushE=1 with MemWriteE=1, RegWriteE=1 → memory is unchanged and RegWriteM=0. FlushE=1 during StallM=1 → the held instruction completes normally.
- sh 0xBEEF at 0x31:
  - with MSX_ALIGN_CHECK_EN: MisalignM=1 and word 0x30 is unchanged.
  - without it: MisalignM=0 and lanes 1:0 of word 0x30 = 0xBEEF.
